traffic_phase_fsm: RTL and testbench
====================================

// Module: traffic_phase_fsm
// PURPOSE
// - Parametrised N-way intersection controller; successor to the two-street traffic FSM.
// - Rotates green round-robin over NUM_WAYS approaches, with sensor-driven green extension,
//   yellow, a latched all-way pedestrian walk phase, and an optional all-red clearance.
// - Drives the external interval timer via start_timer/interval and consumes its expired pulse.
// PARAMETERS
// - NUM_WAYS   2   number of approaches (2..4)
// - WAY_W      1   width of active_way; must equal $clog2(NUM_WAYS)
// PORTS
// - clock        in   1         system clock, rising edge
// - reset_sync   in   1         asynchronous, active-high reset
// - sensor_sync  in   NUM_WAYS  per-way vehicle presence, already synchronised
// - walk_req     in   1         pedestrian request, already synchronised (level or pulse)
// - expired      in   1         1-cycle pulse from the interval timer
// - start_timer  out  1         1-cycle pulse: load and start the timer with `interval`
// - interval     out  2         0=T_BASE 1=T_EXT 2=T_YEL 3=T_CLR
// - wr_reset     out  1         1-cycle pulse: walk request served
// - green/yellow/red out NUM_WAYS  one-hot-per-way lamp drives
// - walk         out  1         pedestrian walk lamp
// - active_way   out  WAY_W     way currently holding green/yellow
// BEHAVIOUR
// - One clock, reset_sync asynchronous and active-high. All outputs registered.
// - Reset: state=GREEN_BASE, active_way=0, green=1<<0, yellow=0, red=~(1<<0), walk=0,
//   interval=0, start_timer=0, wr_reset=0, walk_pending=0.
// - First rising edge after reset release: start_timer=1 for one cycle (timer for GREEN_BASE).
// - States: GREEN_BASE(int 0) -> GREEN_EXT(int 1) -> YELLOW(int 2) -> [ALL_RED(int 3)] -> WALK(int 1)
// - Transitions happen only on an edge where expired=1 is sampled. That edge updates state,
//   lamps, interval and active_way together. start_timer=1 for exactly the first cycle of the
//   new state. expired is ignored in any cycle where start_timer=1.
// - GREEN_BASE: on expired -> GREEN_EXT if sensor_sync[active_way]=1, else YELLOW.
//   At most one extension per green.
// - GREEN_EXT: on expired -> YELLOW.
// - YELLOW: on expired -> ALL_RED (macro on). Otherwise -> WALK if walk_pending.
//   Otherwise -> GREEN_BASE of next way (active_way+1, wraps NUM_WAYS-1 -> 0).
// - WALK: all red, walk=1, active_way held. On entry, wr_reset=1 for one cycle and
//   walk_pending clears. On expired -> GREEN_BASE of next way.
// - walk_pending: set by walk_req=1 in any cycle. A request in the WALK entry cycle is
//   absorbed (counted as served). A request during WALK stays pending until the next walk.
// - interval is held constant for the whole state. Exactly one lamp per way is on, except
//   in WALK/ALL_RED, where all ways are red.
// - Asserting reset_sync mid-phase forces the reset values immediately. No pulse is emitted
//   until release.
// CONFIGURATION
// - TLS_ALL_RED_EN defined: YELLOW -> ALL_RED (all red, walk=0, interval=3) -> on expired ->
//   WALK or next GREEN_BASE, using the rules above.
// - TLS_ALL_RED_EN undefined: ALL_RED state is not compiled. interval=3 is never driven.
// STRUCTURE
// - Package traffic_pkg: state enum (GREEN_BASE, GREEN_EXT, YELLOW, ALL_RED, WALK) and
//   interval codes T_BASE=0, T_EXT=1, T_YEL=2, T_CLR=3.
// - One sub-module, tls_walk_latch: walk_req set / wr_reset clear register with
//   clear-wins-same-cycle absorption.
// - Lamp decode and next-way wrap are local to traffic_phase_fsm.
// TESTING
// - Reset release, NUM_WAYS=3, no sensor/walk: expired every 4 cycles ->
//   green 001->010->100->001 with yellow between greens; start_timer one pulse per state.
// - sensor_sync[0]=1 at GREEN_BASE expiry -> GREEN_EXT with interval=1. A second expiry goes
//   to YELLOW even if the sensor is still 1.
// - walk_req pulse during way-1 green -> after way-1 YELLOW: WALK, walk=1, red=all,
//   wr_reset one pulse, then green of way 2.
// - walk_req held high across WALK entry -> no second WALK. walk_req after entry -> WALK
//   after the next yellow.
// - expired=1 in the start_timer cycle -> ignored, state unchanged. reset_sync pulse
//   mid-YELLOW -> immediate return to way-0 GREEN_BASE values.
// - TLS_ALL_RED_EN on: YELLOW expiry -> all red, interval=3, walk=0 for one timer period,
//   then next green.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types for the N-way traffic phase controller: phase enum and timer interval codes.
package traffic_pkg;

  typedef enum logic [2:0] {
    GREEN_BASE,
    GREEN_EXT,
    YELLOW,
    ALL_RED,
    WALK
  } state_e;

  localparam logic [1:0] T_BASE = 2'd0;
  localparam logic [1:0] T_EXT  = 2'd1;
  localparam logic [1:0] T_YEL  = 2'd2;
  localparam logic [1:0] T_CLR  = 2'd3;

  // Timer interval loaded on entry to each phase; WALK reuses the extension length.
  function automatic logic [1:0] state_interval(input state_e s);
    case (s)
      GREEN_EXT, WALK: state_interval = T_EXT;
      YELLOW:          state_interval = T_YEL;
      ALL_RED:         state_interval = T_CLR;
      default:         state_interval = T_BASE;
    endcase
  endfunction

endpackage

// File: rtl/tls_walk_latch.sv
// Pedestrian request latch: set by walk_req, cleared when the walk is served.
module tls_walk_latch (
  input  logic clock,
  input  logic reset_sync,
  input  logic walk_req_i,
  input  logic clear_i,
  output logic pending_o
);

  logic pending_q;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset_sync) begin
    if (reset_sync) begin
      pending_q <= 1'b0;
    end else if (clear_i) begin
      // A request arriving in the serving cycle is absorbed by that walk.
      pending_q <= 1'b0;
    end else if (walk_req_i) begin
      pending_q <= 1'b1;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/traffic_phase_fsm.sv
// N-way round-robin intersection controller with green extension and latched pedestrian walk.
// Define TLS_ALL_RED_EN to insert an all-red clearance phase after every yellow.
module traffic_phase_fsm
  import traffic_pkg::*;
#(
  parameter int NUM_WAYS = 2,
  parameter int WAY_W    = 1
) (
  input  logic                clock,
  input  logic                reset_sync,
  input  logic [NUM_WAYS-1:0] sensor_sync,
  input  logic                walk_req,
  input  logic                expired,
  output logic                start_timer,
  output logic [1:0]          interval,
  output logic                wr_reset,
  output logic [NUM_WAYS-1:0] green,
  output logic [NUM_WAYS-1:0] yellow,
  output logic [NUM_WAYS-1:0] red,
  output logic                walk,
  output logic [WAY_W-1:0]    active_way
);

  localparam logic [NUM_WAYS-1:0] WAY0_ONEHOT = NUM_WAYS'(1);

  state_e              state_q, state_d;
  logic [WAY_W-1:0]    way_q, way_d, next_way;
  logic [NUM_WAYS-1:0] green_q, yellow_q, red_q, onehot_d, green_d, yellow_d;
  logic [1:0]          interval_q;
  logic                start_timer_q, wr_reset_q, walk_q, fresh_q;
  logic                advance, walk_pending;

  tls_walk_latch u_walk_latch (
    .clock      (clock),
    .reset_sync (reset_sync),
    .walk_req_i (walk_req),
    .clear_i    (wr_reset_q),
    .pending_o  (walk_pending)
  );

  // The timer is busy being loaded while start_timer is high, so a stale expired is dropped.
  assign advance  = expired && !start_timer_q && !fresh_q;
  assign next_way = (way_q == WAY_W'(NUM_WAYS - 1)) ? '0 : way_q + WAY_W'(1);

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    way_d   = way_q;
    if (advance) begin
      case (state_q)
        GREEN_BASE: state_d = sensor_sync[way_q] ? GREEN_EXT : YELLOW;
        GREEN_EXT:  state_d = YELLOW;
`ifdef TLS_ALL_RED_EN
        YELLOW:     state_d = ALL_RED;
        ALL_RED: begin
`else
        YELLOW: begin
`endif
          if (walk_pending) begin
            state_d = WALK;
          end else begin
            state_d = GREEN_BASE;
            way_d   = next_way;
          end
        end
        WALK: begin
          state_d = GREEN_BASE;
          way_d   = next_way;
        end
        default: state_d = GREEN_BASE;
      endcase
    end
  end

  always_comb begin
    onehot_d = WAY0_ONEHOT << way_d;
    green_d  = (state_d == GREEN_BASE || state_d == GREEN_EXT) ? onehot_d : '0;
    yellow_d = (state_d == YELLOW) ? onehot_d : '0;
  end

  // Lamps are registered from the next state so they change on the same edge as the phase.
  always_ff @(posedge clock or posedge reset_sync) begin
    if (reset_sync) begin
      state_q       <= GREEN_BASE;
      way_q         <= '0;
      green_q       <= WAY0_ONEHOT;
      yellow_q      <= '0;
      red_q         <= ~WAY0_ONEHOT;
      walk_q        <= 1'b0;
      interval_q    <= T_BASE;
      start_timer_q <= 1'b0;
      wr_reset_q    <= 1'b0;
      fresh_q       <= 1'b1;
    end else begin
      fresh_q       <= 1'b0;
      start_timer_q <= fresh_q || advance;
      wr_reset_q    <= advance && (state_d == WALK);
      state_q       <= state_d;
      way_q         <= way_d;
      green_q       <= green_d;
      yellow_q      <= yellow_d;
      red_q         <= ~(green_d | yellow_d);
      walk_q        <= (state_d == WALK);
      interval_q    <= state_interval(state_d);
    end
  end

  assign start_timer = start_timer_q;
  assign interval    = interval_q;
  assign wr_reset    = wr_reset_q;
  assign green       = green_q;
  assign yellow      = yellow_q;
  assign red         = red_q;
  assign walk        = walk_q;
  assign active_way  = way_q;

endmodule

// File: tb/tb_traffic_phase_fsm.sv
// Directed bench for traffic_phase_fsm with NUM_WAYS=3; follows TLS_ALL_RED_EN when defined.
module tb_traffic_phase_fsm;

  localparam int NW = 3;
  localparam int WW = 2;

  logic          clock = 1'b0;
  logic          reset_sync = 1'b1;
  logic [NW-1:0] sensor_sync = '0;
  logic          walk_req = 1'b0;
  logic          expired = 1'b0;
  logic          start_timer;
  logic [1:0]    interval;
  logic          wr_reset;
  logic [NW-1:0] green, yellow, red;
  logic          walk;
  logic [WW-1:0] active_way;

  int n_checks = 0;
  int n_errors = 0;

  traffic_phase_fsm #(.NUM_WAYS(NW), .WAY_W(WW)) dut (
    .clock       (clock),
    .reset_sync  (reset_sync),
    .sensor_sync (sensor_sync),
    .walk_req    (walk_req),
    .expired     (expired),
    .start_timer (start_timer),
    .interval    (interval),
    .wr_reset    (wr_reset),
    .green       (green),
    .yellow      (yellow),
    .red         (red),
    .walk        (walk),
    .active_way  (active_way)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Idle cycles with expired low, then one expired pulse; start_timer must be low after entry cycle.
  task automatic advance(input string tag, input int idle);
    tick();
    check({tag, ".st_low"}, 32'(start_timer), 32'd0);
    for (int i = 1; i < idle; i++) tick();
    expired = 1'b1;
    tick();
    expired = 1'b0;
  endtask

  task automatic expect_state(input string tag, input logic [NW-1:0] g, input logic [NW-1:0] y,
                              input logic [NW-1:0] r, input logic w, input logic [1:0] iv,
                              input logic [WW-1:0] way, input logic wr);
    check({tag, ".green"},  32'(green),       32'(g));
    check({tag, ".yellow"}, 32'(yellow),      32'(y));
    check({tag, ".red"},    32'(red),         32'(r));
    check({tag, ".walk"},   32'(walk),        32'(w));
    check({tag, ".intv"},   32'(interval),    32'(iv));
    check({tag, ".way"},    32'(active_way),  32'(way));
    check({tag, ".wr"},     32'(wr_reset),    32'(wr));
    check({tag, ".st"},     32'(start_timer), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset values
    tick(); tick(); tick();
    check("rst.green",  32'(green),       32'h1);
    check("rst.yellow", 32'(yellow),      32'h0);
    check("rst.red",    32'(red),         32'h6);
    check("rst.walk",   32'(walk),        32'h0);
    check("rst.intv",   32'(interval),    32'h0);
    check("rst.way",    32'(active_way),  32'h0);
    check("rst.st",     32'(start_timer), 32'h0);
    check("rst.wr",     32'(wr_reset),    32'h0);

    reset_sync = 1'b0;
    tick();
    expect_state("first", 3'b001, 3'b000, 3'b110, 1'b0, 2'd0, 2'd0, 1'b0);

    // Plain rotation, expired every 4 cycles
    advance("rot1", 3); expect_state("y0",  3'b000, 3'b001, 3'b110, 1'b0, 2'd2, 2'd0, 1'b0);
    advance("rot2", 3); expect_state("g1",  3'b010, 3'b000, 3'b101, 1'b0, 2'd0, 2'd1, 1'b0);
    advance("rot3", 3); expect_state("y1",  3'b000, 3'b010, 3'b101, 1'b0, 2'd2, 2'd1, 1'b0);
    advance("rot4", 3); expect_state("g2",  3'b100, 3'b000, 3'b011, 1'b0, 2'd0, 2'd2, 1'b0);
    advance("rot5", 3); expect_state("y2",  3'b000, 3'b100, 3'b011, 1'b0, 2'd2, 2'd2, 1'b0);
    advance("rot6", 3); expect_state("g0w", 3'b001, 3'b000, 3'b110, 1'b0, 2'd0, 2'd0, 1'b0);

    // Sensor extension, only once per green
    sensor_sync = 3'b001;
    advance("ext1", 3); expect_state("ext",   3'b001, 3'b000, 3'b110, 1'b0, 2'd1, 2'd0, 1'b0);
    advance("ext2", 3); expect_state("extY",  3'b000, 3'b001, 3'b110, 1'b0, 2'd2, 2'd0, 1'b0);
    sensor_sync = 3'b000;
    advance("ext3", 3); expect_state("extG1", 3'b010, 3'b000, 3'b101, 1'b0, 2'd0, 2'd1, 1'b0);

    // Walk pulse during way-1 green
    walk_req = 1'b1; tick(); walk_req = 1'b0;
    advance("wk1", 2); expect_state("wkY1", 3'b000, 3'b010, 3'b101, 1'b0, 2'd2, 2'd1, 1'b0);
    advance("wk2", 3); expect_state("wkW",  3'b000, 3'b000, 3'b111, 1'b1, 2'd1, 2'd1, 1'b1);
    tick();
    check("wk.wr_pulse", 32'(wr_reset), 32'd0);
    advance("wk3", 2); expect_state("wkG2", 3'b100, 3'b000, 3'b011, 1'b0, 2'd0, 2'd2, 1'b0);

    // Request held across WALK entry is absorbed
    walk_req = 1'b1;
    advance("hd1", 3); expect_state("hdY2", 3'b000, 3'b100, 3'b011, 1'b0, 2'd2, 2'd2, 1'b0);
    advance("hd2", 3); expect_state("hdW",  3'b000, 3'b000, 3'b111, 1'b1, 2'd1, 2'd2, 1'b1);
    tick();
    walk_req = 1'b0;
    advance("hd3", 2); expect_state("hdG0", 3'b001, 3'b000, 3'b110, 1'b0, 2'd0, 2'd0, 1'b0);
    advance("hd4", 3); expect_state("hdY0", 3'b000, 3'b001, 3'b110, 1'b0, 2'd2, 2'd0, 1'b0);
    advance("hd5", 3); expect_state("hdG1", 3'b010, 3'b000, 3'b101, 1'b0, 2'd0, 2'd1, 1'b0);

    // Request during WALK stays pending for the next walk
    walk_req = 1'b1; tick(); walk_req = 1'b0;
    advance("dw1", 2); expect_state("dwY1",  3'b000, 3'b010, 3'b101, 1'b0, 2'd2, 2'd1, 1'b0);
    advance("dw2", 3); expect_state("dwW1",  3'b000, 3'b000, 3'b111, 1'b1, 2'd1, 2'd1, 1'b1);
    tick();
    walk_req = 1'b1; tick(); walk_req = 1'b0;
    advance("dw3", 1); expect_state("dwG2",  3'b100, 3'b000, 3'b011, 1'b0, 2'd0, 2'd2, 1'b0);
    advance("dw4", 3); expect_state("dwY2",  3'b000, 3'b100, 3'b011, 1'b0, 2'd2, 2'd2, 1'b0);
    advance("dw5", 3); expect_state("dwW2",  3'b000, 3'b000, 3'b111, 1'b1, 2'd1, 2'd2, 1'b1);
    tick();
    advance("dw6", 2); expect_state("dwG0",  3'b001, 3'b000, 3'b110, 1'b0, 2'd0, 2'd0, 1'b0);

    // expired in the start_timer cycle is ignored
    expired = 1'b1; tick(); expired = 1'b0;
    check("ign.green", 32'(green),       32'h1);
    check("ign.yel",   32'(yellow),      32'h0);
    check("ign.intv",  32'(interval),    32'h0);
    check("ign.st",    32'(start_timer), 32'h0);
    advance("ign1", 2); expect_state("ignY0", 3'b000, 3'b001, 3'b110, 1'b0, 2'd2, 2'd0, 1'b0);

    // Reset mid-YELLOW of way 1, with a walk pending that reset must discard
    advance("rs1", 3); expect_state("rsG1", 3'b010, 3'b000, 3'b101, 1'b0, 2'd0, 2'd1, 1'b0);
    walk_req = 1'b1; tick(); walk_req = 1'b0;
    advance("rs2", 2); expect_state("rsY1", 3'b000, 3'b010, 3'b101, 1'b0, 2'd2, 2'd1, 1'b0);
    tick();
    reset_sync = 1'b1;
    #1;
    check("mrst.green",  32'(green),       32'h1);
    check("mrst.yellow", 32'(yellow),      32'h0);
    check("mrst.red",    32'(red),         32'h6);
    check("mrst.way",    32'(active_way),  32'h0);
    check("mrst.intv",   32'(interval),    32'h0);
    check("mrst.st",     32'(start_timer), 32'h0);
    tick();
    check("mrst.hold_st", 32'(start_timer), 32'h0);
    reset_sync = 1'b0;
    tick();
    expect_state("mrstG0", 3'b001, 3'b000, 3'b110, 1'b0, 2'd0, 2'd0, 1'b0);
    advance("rs3", 3); expect_state("rsY0b", 3'b000, 3'b001, 3'b110, 1'b0, 2'd2, 2'd0, 1'b0);
    advance("rs4", 3); expect_state("rsG1b", 3'b010, 3'b000, 3'b101, 1'b0, 2'd0, 2'd1, 1'b0);

    // Yellow exit: all-red clearance when enabled, otherwise straight to next green
    advance("ar1", 3); expect_state("arY1", 3'b000, 3'b010, 3'b101, 1'b0, 2'd2, 2'd1, 1'b0);
`ifdef TLS_ALL_RED_EN
    advance("ar2", 3); expect_state("arR",  3'b000, 3'b000, 3'b111, 1'b0, 2'd3, 2'd1, 1'b0);
    advance("ar3", 3); expect_state("arG2", 3'b100, 3'b000, 3'b011, 1'b0, 2'd0, 2'd2, 1'b0);
`else
    advance("ar2", 3); expect_state("arG2", 3'b100, 3'b000, 3'b011, 1'b0, 2'd0, 2'd2, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
